// File: rtl/unidade_controle_jogo.sv
// Moore control unit for the memory game: sequences clear, wait-for-play, register,
// compare and advance/finish, with a per-play inactivity timeout and a debug state code.
module unidade_controle_jogo #(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int TIMEOUT_W      = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERROU   = 4'hE
  } estado_t;

  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CICLOS - 1);

  estado_t               state_q, state_d;
  logic [TIMEOUT_W-1:0]  tmo_q, tmo_d;

  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    case (state_q)
      INICIAL:     if (iniciar) state_d = PREPARACAO;
      PREPARACAO:  state_d = ESPERA;
      ESPERA: begin
        // Saturate at the last value so the counter can never wrap.
        tmo_d = (tmo_q == TMO_LAST) ? tmo_q : tmo_q + 1'b1;
        if (jogada_feita)            state_d = REGISTRA;
        else if (tmo_q == TMO_LAST)  state_d = FIM_TIMEOUT;
      end
      REGISTRA:    state_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual)     state_d = FIM_ERROU;
        else if (fimC)  state_d = FIM_ACERTOU;
        else            state_d = PROXIMO;
      end
      PROXIMO:     state_d = ESPERA;
      FIM_ACERTOU,
      FIM_ERROU,
      FIM_TIMEOUT: if (iniciar) state_d = PREPARACAO;
      default:     state_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INICIAL;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  // Outputs depend on the state register only, so reset clears them without a clock.
  always_comb begin
    zeraC     = 1'b0;
    contaC    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    db_estado = 4'hF;
    case (state_q)
      INICIAL:     db_estado = 4'h0;
      PREPARACAO: begin db_estado = 4'h1; zeraC = 1'b1; zeraR = 1'b1; end
      ESPERA:      db_estado = 4'h2;
      REGISTRA:   begin db_estado = 4'h4; registraR = 1'b1; end
      COMPARACAO:  db_estado = 4'h5;
      PROXIMO:    begin db_estado = 4'h6; contaC = 1'b1; end
      FIM_ACERTOU: begin db_estado = 4'hA; pronto = 1'b1; acertou = 1'b1; end
      FIM_ERROU:  begin db_estado = 4'hE; pronto = 1'b1; errou = 1'b1; end
      FIM_TIMEOUT: begin
        db_estado = 4'hD; pronto = 1'b1; errou = 1'b1; timeout = 1'b1;
      end
      default:     db_estado = 4'hF;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Bench for unidade_controle_jogo: directed scenarios plus randomized rounds checked
// against a trace-level model that expands each round into its expected state codes.
module tb_unidade_controle_jogo;

  localparam int T = 8;

  logic       clock = 1'b0;
  logic       reset, iniciar, jogada_feita, igual, fimC;
  logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int n_conta, n_reg, n_zera;

  typedef struct packed {logic ini; logic jf; logic ig; logic fc;} stim_t;
  stim_t      stim_q[$];
  logic [3:0] exp_q[$];

  unidade_controle_jogo #(.TIMEOUT_CICLOS(T), .TIMEOUT_W(4)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
    .igual(igual), .fimC(fimC), .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR),
    .registraR(registraR), .pronto(pronto), .acertou(acertou), .errou(errou),
    .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Output table for each state code: {zeraC,contaC,zeraR,registraR,pronto,acertou,errou,timeout}
  function automatic logic [7:0] outs_of(input logic [3:0] code);
    case (code)
      4'h1:    return 8'b1010_0000;
      4'h4:    return 8'b0001_0000;
      4'h6:    return 8'b0100_0000;
      4'hA:    return 8'b0000_1100;
      4'hE:    return 8'b0000_1010;
      4'hD:    return 8'b0000_1011;
      default: return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [7:0] dut_outs();
    return {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};
  endfunction

  function automatic logic r();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    if (contaC) n_conta++;
    if (registraR) n_reg++;
    if (zeraC) n_zera++;
  endtask

  // From a waiting state: pulse a play and walk it through register/compare.
  task automatic do_play(input logic pass, input logic last);
    jogada_feita = 1'b1; igual = pass; fimC = last;
    tick();
    jogada_feita = 1'b0;
    tick();
    tick();
    if (pass && !last) tick();
    igual = 1'b0; fimC = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; iniciar = 1'b0; jogada_feita = 1'b0; igual = 1'b0; fimC = 1'b0;
    #12;
    checks++;
    if ({db_estado, dut_outs()} !== 12'h000) begin
      errors++;
      $display("FAIL reset_hold: got db=%h outs=%b, expected db=0 outs=0", db_estado, dut_outs());
    end
    @(negedge clock); reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({db_estado, dut_outs()} !== 12'h000) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got db=%h outs=%b, expected db=0 outs=0", i, db_estado, dut_outs());
      end
    end
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    checks++;
    if ({db_estado, dut_outs()} !== {4'h1, outs_of(4'h1)}) begin
      errors++;
      $display("FAIL start_prep: got db=%h outs=%b, expected db=1 outs=%b", db_estado, dut_outs(), outs_of(4'h1));
    end
    tick();
    checks++;
    if ({db_estado, dut_outs()} !== {4'h2, outs_of(4'h2)}) begin
      errors++;
      $display("FAIL start_wait: got db=%h outs=%b, expected db=2 outs=0", db_estado, dut_outs());
    end
  endtask

  task automatic test_full_round();
    n_conta = 0; n_reg = 0;
    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      do_play(1'b1, k == 15);
    end
    checks++;
    if (n_conta != 15 || n_reg != 16) begin
      errors++;
      $display("FAIL full_round_pulses: got contaC=%0d registraR=%0d, expected 15 and 16", n_conta, n_reg);
    end
    checks++;
    if ({db_estado, dut_outs()} !== {4'hA, outs_of(4'hA)}) begin
      errors++;
      $display("FAIL full_round_end: got db=%h outs=%b, expected db=a outs=%b", db_estado, dut_outs(), outs_of(4'hA));
    end
  endtask

  task automatic test_wrong_play();
    iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
    n_conta = 0;
    for (int k = 0; k < 3; k++) do_play(k < 2, 1'b0);
    checks++;
    if ({db_estado, dut_outs()} !== {4'hE, outs_of(4'hE)}) begin
      errors++;
      $display("FAIL wrong_play_end: got db=%h outs=%b, expected db=e outs=%b", db_estado, dut_outs(), outs_of(4'hE));
    end
    checks++;
    if (n_conta != 2) begin
      errors++;
      $display("FAIL wrong_play_conta: got %0d contaC pulses, expected 2", n_conta);
    end
  endtask

  task automatic test_timeout();
    int n;
    iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
    n = (db_estado == 4'h2) ? 1 : 0;
    for (int i = 0; i < 50 && db_estado == 4'h2; i++) begin
      tick();
      if (db_estado == 4'h2) n++;
    end
    checks++;
    if (n != T || {db_estado, dut_outs()} !== {4'hD, outs_of(4'hD)}) begin
      errors++;
      $display("FAIL timeout_len: got %0d wait cycles then db=%h outs=%b, expected %0d then db=d outs=%b",
               n, db_estado, dut_outs(), T, outs_of(4'hD));
    end
    iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
    repeat (T - 1) tick();
    jogada_feita = 1'b1;
    tick();
    jogada_feita = 1'b0;
    checks++;
    if ({db_estado, dut_outs()} !== {4'h4, outs_of(4'h4)}) begin
      errors++;
      $display("FAIL play_beats_timeout: got db=%h outs=%b, expected db=4 outs=%b", db_estado, dut_outs(), outs_of(4'h4));
    end
    tick(); igual = 1'b0; tick();
  endtask

  task automatic test_restart_hold();
    int n;
    logic [3:0] seq [3];
    n_zera = 0;
    iniciar = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      seq[i] = db_estado;
    end
    iniciar = 1'b0;
    checks++;
    if (seq[0] !== 4'h1 || seq[1] !== 4'h2 || seq[2] !== 4'h2 || n_zera != 1) begin
      errors++;
      $display("FAIL restart_hold: got seq=%h,%h,%h zeraC=%0d, expected 1,2,2 zeraC=1", seq[0], seq[1], seq[2], n_zera);
    end
    n = 2;
    for (int i = 0; i < 50 && db_estado == 4'h2; i++) begin
      tick();
      if (db_estado == 4'h2) n++;
    end
    checks++;
    if (n != T || db_estado !== 4'hD) begin
      errors++;
      $display("FAIL restart_tmo: got %0d wait cycles then db=%h, expected %0d then db=d", n, db_estado, T);
    end
  endtask

  task automatic test_async_reset();
    iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
    jogada_feita = 1'b1; igual = 1'b1; tick(); jogada_feita = 1'b0; tick(); tick();
    igual = 1'b0;
    checks++;
    if (db_estado !== 4'h6 || contaC !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: got db=%h contaC=%b, expected db=6 contaC=1", db_estado, contaC);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({db_estado, dut_outs()} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got db=%h outs=%b, expected db=0 outs=0", db_estado, dut_outs());
    end
    tick();
    reset = 1'b1;
    jogada_feita = 1'b1;
    tick();
    jogada_feita = 1'b0;
    tick();
    checks++;
    if ({db_estado, dut_outs()} !== 12'h000) begin
      errors++;
      $display("FAIL spurious_play: got db=%h outs=%b, expected db=0 outs=0", db_estado, dut_outs());
    end
  endtask

  task automatic push(input logic ini, input logic jf, input logic ig, input logic fc, input logic [3:0] e);
    stim_q.push_back({ini, jf, ig, fc});
    exp_q.push_back(e);
  endtask

  task automatic test_random_rounds();
    stim_t s;
    logic [3:0] e, fin_code;
    logic pass, last, done;
    for (int rnd = 0; rnd < 8; rnd++) begin
      push(1'b1, 1'b0, r(), r(), 4'h1);
      push(r(), r(), r(), r(), 4'h2);
      done = 1'b0;
      fin_code = 4'h0;
      for (int k = 0; k < 16 && !done; k++) begin
        if ($urandom_range(0, 11) == 0) begin
          for (int i = 1; i <= T; i++) push(r(), 1'b0, r(), r(), (i < T) ? 4'h2 : 4'hD);
          fin_code = 4'hD; done = 1'b1;
        end else begin
          repeat ($urandom_range(0, T - 1)) push(r(), 1'b0, r(), r(), 4'h2);
          pass = ($urandom_range(0, 9) != 0);
          last = (k == 15);
          push(r(), 1'b1, r(), r(), 4'h4);
          push(r(), r(), r(), r(), 4'h5);
          e = !pass ? 4'hE : (last ? 4'hA : 4'h6);
          push(r(), r(), pass, last, e);
          if (e == 4'h6) push(r(), r(), r(), r(), 4'h2);
          else begin fin_code = e; done = 1'b1; end
        end
      end
      repeat ($urandom_range(1, 3)) push(1'b0, r(), r(), r(), fin_code);
    end
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      iniciar = s.ini; jogada_feita = s.jf; igual = s.ig; fimC = s.fc;
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({db_estado, dut_outs()} !== {e, outs_of(e)}) begin
        errors++;
        $display("FAIL random_trace: got db=%h outs=%b, expected db=%h outs=%b", db_estado, dut_outs(), e, outs_of(e));
      end
    end
    iniciar = 1'b0; jogada_feita = 1'b0; igual = 1'b0; fimC = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_round();
    test_wrong_play();
    test_timeout();
    test_restart_hold();
    test_async_reset();
    test_random_rounds();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
